// File: rtl/serial_ecc_deserializer.sv
// Reassembles LSB-first serial words from the Hamming shift register, regenerates
// parity over data bits [3:0], and queues each word for a valid/ready consumer.
module serial_ecc_deserializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic                     frame_start,
    output logic [WIDTH-1:0]         out_data,
    output logic [2:0]               out_p,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    input  logic                     clear_ovf,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_ASSEMBLE} state_t;

    typedef struct packed {
        logic [2:0]       p;
        logic [WIDTH-1:0] d;
    } entry_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_bit_count, w_cnt_nxt, w_idx;
    logic [WIDTH-2:0] r_shift;
    logic             w_complete, w_store;
    logic [WIDTH-1:0] w_word;
    logic [2:0]       w_par;

    entry_t           r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [OW-1:0]    r_count;
    logic             r_ovf;
    logic             w_pop, w_full, w_push, w_drop;

    // ---------------- assembler FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = bit_valid ? S_ASSEMBLE : S_IDLE;
        end else if (bit_valid) begin
            case (r_state)
                S_IDLE:     w_state_nxt = S_ASSEMBLE;
                S_ASSEMBLE: if (r_bit_count == LAST) w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    // frame_start restarts at bit 0 and suppresses completion of the old word
    always_comb begin
        w_complete = 1'b0;
        w_store    = bit_valid;
        w_idx      = r_bit_count;
        w_cnt_nxt  = r_bit_count;
        if (frame_start) begin
            w_idx     = '0;
            w_cnt_nxt = bit_valid ? CW'(1) : '0;
        end else if (bit_valid) begin
            if (r_state == S_IDLE) begin
                w_idx     = '0;
                w_cnt_nxt = CW'(1);
            end else if (r_bit_count == LAST) begin
                w_complete = 1'b1;
                w_store    = 1'b0;
                w_cnt_nxt  = '0;
            end else begin
                w_cnt_nxt = r_bit_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_count <= '0;
            r_shift     <= '0;
        end else begin
            r_bit_count <= w_cnt_nxt;
            if (w_store) r_shift[w_idx] <= bit_in;
        end
    end

    // The final bit bypasses the shift register straight into the FIFO entry
    assign w_word = {bit_in, r_shift};
    assign w_par  = {w_word[0] ^ w_word[1] ^ w_word[2],
                     w_word[0] ^ w_word[1] ^ w_word[3],
                     w_word[0] ^ w_word[2] ^ w_word[3]};

    // ---------------- output FIFO ----------------
    assign w_pop  = out_valid && out_ready;
    assign w_full = (r_count == OW'(DEPTH));
    assign w_push = w_complete && (!w_full || w_pop);
    assign w_drop = w_complete && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= '{p: w_par, d: w_word};
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OW'(1);
                2'b01:   r_count <= r_count - OW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)         r_ovf <= 1'b1;
            else if (clear_ovf) r_ovf <= 1'b0;
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rptr].d;
    assign out_p     = r_mem[r_rptr].p;
    assign overflow  = r_ovf;
    assign bit_count = r_bit_count;

endmodule

// File: tb/tb_serial_ecc_deserializer.sv
// Scoreboard bench: a bit-queue model predicts words, FIFO occupancy and overflow;
// a negedge monitor compares the DUT head against the expected queue.
module tb_serial_ecc_deserializer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic bit_valid = 1'b0, bit_in = 1'b0, frame_start = 1'b0;
    logic out_ready = 1'b0, clear_ovf = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [2:0] out_p;
    logic out_valid, overflow;
    logic [$clog2(WIDTH)-1:0] bit_count;

    int tests = 0, fails = 0;

    typedef struct packed {
        logic [2:0]       p;
        logic [WIDTH-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    bit   mbits[$];
    int   mcount = 0;
    bit   movf = 1'b0;
    bit   m_pop, m_done, m_drop;
    logic [WIDTH-1:0] m_w;

    serial_ecc_deserializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .frame_start(frame_start), .out_data(out_data), .out_p(out_p),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
        .clear_ovf(clear_ovf), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_par(input logic [WIDTH-1:0] d);
        return {d[0] ^ d[1] ^ d[2], d[0] ^ d[1] ^ d[3], d[0] ^ d[2] ^ d[3]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: collected bits as a queue, FIFO as an occupancy count
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mbits.delete();
            exp_q.delete();
            mcount = 0;
            movf   = 1'b0;
        end else begin
            m_pop  = (mcount > 0) && out_ready;
            m_done = 1'b0;
            m_w    = '0;
            if (frame_start) mbits.delete();
            if (bit_valid) begin
                if (!frame_start && mbits.size() == WIDTH - 1) begin
                    foreach (mbits[i]) m_w[i] = mbits[i];
                    m_w[WIDTH-1] = bit_in;
                    mbits.delete();
                    m_done = 1'b1;
                end else begin
                    mbits.push_back(bit_in);
                end
            end
            m_drop = m_done && (mcount >= DEPTH) && !m_pop;
            if (m_pop) mcount--;
            if (m_done && !m_drop) begin
                exp_q.push_back({ref_par(m_w), m_w});
                mcount++;
            end
            if (m_drop)         movf = 1'b1;
            else if (clear_ovf) movf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", out_valid, mcount != 0);
            chk("overflow", overflow, movf);
            chk("bit_count", bit_count, mbits.size());
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL head: out_valid=1 with data %0h, expected no word", out_data);
                end else begin
                    chk("head_data", out_data, exp_q[0].d);
                    chk("head_p", out_p, exp_q[0].p);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input bit bv, input bit bi, input bit fs);
        bit_valid   = bv;
        bit_in      = bi;
        frame_start = fs;
        @(posedge clk);
        #1;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        clear_ovf   = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input int gap);
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, w[i], 1'b0);
            repeat (gap) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic pop_n(input int n);
        out_ready = 1'b1;
        repeat (n) step(1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_p", out_p, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_cnt", bit_count, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // single word
        send_word(8'hA5, 0);
        chk("a5_valid", out_valid, 1);
        chk("a5_data", out_data, 8'hA5);
        chk("a5_p", out_p, 3'b010);
        pop_n(1);
        chk("a5_popped", out_valid, 0);

        // gapped bits
        w = 8'h3C;
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, w[i], 1'b0);
            repeat (3) begin
                step(1'b0, 1'b0, 1'b0);
                chk("gap_cnt", bit_count, (i + 1) % WIDTH);
            end
        end
        chk("3c_data", out_data, 8'h3C);
        chk("3c_p", out_p, 3'b110);
        pop_n(1);

        // resync
        w = 8'h16;
        for (int i = 0; i < 5; i++) step(1'b1, w[i], 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("resync_cnt", bit_count, 1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
        chk("ff_data", out_data, 8'hFF);
        chk("ff_p", out_p, 3'b111);
        pop_n(1);
        chk("ff_single", out_valid, 0);

        // overflow
        send_word(8'h01, 0);
        send_word(8'h02, 0);
        send_word(8'h03, 0);
        chk("ovf_set", overflow, 1);
        pop_n(2);
        chk("ovf_drained", out_valid, 0);
        clear_ovf = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("ovf_clr", overflow, 0);

        // full plus simultaneous pop
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        w = 8'h77;
        for (int i = 0; i < WIDTH - 1; i++) step(1'b1, w[i], 1'b0);
        out_ready = 1'b1;
        step(1'b1, w[WIDTH-1], 1'b0);
        out_ready = 1'b0;
        chk("fp_ovf", overflow, 0);
        chk("fp_head", out_data, 8'h22);
        pop_n(1);
        chk("fp_second", out_data, 8'h77);
        chk("fp_valid", out_valid, 1);
        pop_n(1);
        chk("fp_empty", out_valid, 0);

        // reset mid-operation
        send_word(8'h42, 0);
        w = 8'hC9;
        for (int i = 0; i < 3; i++) step(1'b1, w[i], 1'b0);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_p", out_p, 0);
        chk("mr_ovf", overflow, 0);
        chk("mr_cnt", bit_count, 0);
        bit_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        send_word(8'h5A, 0);
        chk("5a_data", out_data, 8'h5A);
        chk("5a_p", out_p, 3'b101);
        pop_n(1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            clear_ovf = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
        end
        pop_n(DEPTH + 2);
        chk("final_empty", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/serial_ecc_deserializer.md
# serial_ecc_deserializer

- Sits directly downstream of the Hamming-protected shift register.
- Samples that register's `serial_out` bit stream, reassembles `WIDTH`-bit words LSB-first, and regenerates the three Hamming parity bits over data bits [3:0].
- Hands each word to the consumer over a valid/ready interface through a small FIFO.
- Reports dropped words through a sticky overflow flag.

## Interface

**Parameters**
- `WIDTH`, 8: word width in bits; minimum 4.
- `DEPTH`, 2: output FIFO depth in words; power of two, minimum 2.

**Ports**
- `clk`, input, 1: clock; all logic is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `bit_valid`, input, 1: `bit_in` is a valid stream bit this cycle; tied to the upstream shift enable.
- `bit_in`, input, 1: serial data bit; the first bit of a word is data bit 0.
- `frame_start`, input, 1: resynchronise; discards any partial word.
- `out_data`, output, `WIDTH`: head-of-FIFO data word.
- `out_p`, output, 3: head-of-FIFO parity, ordered {p3, p2, p1}.
- `out_valid`, output, 1: FIFO is not empty.
- `out_ready`, input, 1: consumer accepts the head word when `out_valid` is also 1.
- `overflow`, output, 1: sticky; a completed word was dropped because the FIFO was full.
- `clear_ovf`, input, 1: synchronous clear of `overflow`.
- `bit_count`, output, `$clog2(WIDTH)`: number of bits collected in the current partial word.

## Operation

**Assembler FSM: IDLE and ASSEMBLE**
- IDLE: `bit_count` = 0.
- IDLE with `bit_valid` = 1: store `bit_in` as bit 0, move to ASSEMBLE, set `bit_count` = 1.
- ASSEMBLE with `bit_valid` = 1: store `bit_in` at position `bit_count`, then increment `bit_count`.
- Completing bit (`bit_count` = `WIDTH`-1 and `bit_valid` = 1):
  - Form the word from the stored bits plus `bit_in`.
  - Push the word and its parity into the FIFO.
  - Return to IDLE with `bit_count` = 0.
- `frame_start` = 1 with `bit_valid` = 0: discard the partial word and go to IDLE.
- `frame_start` = 1 with `bit_valid` = 1: discard the partial word and treat `bit_in` as bit 0 of a new word (`bit_count` becomes 1, state ASSEMBLE).
- `frame_start` overrides word completion: no push occurs.

**Parity, computed at push time over the completed word `d`**
- p1 = d0 ^ d2 ^ d3
- p2 = d0 ^ d1 ^ d3
- p3 = d0 ^ d1 ^ d2
- Bits `WIDTH`-1 down to 4 are not covered.

**FIFO**
- Circular buffer with read and write pointers and an occupancy counter of `$clog2(DEPTH)+1` bits.
- Pointers wrap modulo `DEPTH`.
- Pop occurs when `out_valid` and `out_ready` are both 1.
- `out_data` and `out_p` are driven directly from the head entry.
- Push when not full: accepted.
- Push when full with a pop in the same cycle: both happen; occupancy is unchanged.
- Push when full with no pop: the word is dropped, `overflow` is set, and FIFO contents are unchanged.
- Pop when empty: ignored.

**Overflow flag**
- `clear_ovf` clears `overflow`.
- If `clear_ovf` and a drop occur in the same cycle, `overflow` stays 1 (set wins).

## Timing

**Reset (while `rst` is low, and immediately on its assertion)**
- `out_data` = 0, `out_p` = 0, `out_valid` = 0, `overflow` = 0, `bit_count` = 0.
- FSM in IDLE; FIFO empty, pointers 0.

**Reset mid-word or mid-transfer**
- All partial data and all FIFO contents are lost.
- The first `bit_valid` after release is bit 0.

**Latency and throughput**
- Completing bit sampled at edge N: the word is in the FIFO after edge N.
- If the FIFO was empty, `out_valid` rises in the cycle following edge N.
- One word every `WIDTH` `bit_valid` cycles; gaps between bits are allowed.

**Handshake**
- `out_valid` never drops without a pop.
- Head data is stable while `out_valid` = 1 and `out_ready` = 0.
- Back-to-back pops are allowed every cycle.

## Test plan

- **Single word:** reset, then send 0xA5 LSB-first on consecutive `bit_valid` cycles.
  - Expect `out_data` = 0xA5, `out_p` = 3'b010, with `out_valid` rising one cycle after the 8th bit edge.
  - Pop with `out_ready` = 1; expect `out_valid` = 0 on the next cycle.
- **Gapped bits:** send 0x3C with `bit_valid` low for 3 cycles between every bit.
  - Expect `out_data` = 0x3C, `out_p` = 3'b110.
  - `bit_count` holds its value during the gaps.
- **Resync:** send 5 bits, then pulse `frame_start` together with `bit_valid`, then 7 more bits of 0xFF.
  - Expect exactly one word, 0xFF, with `out_p` = 3'b111; the partial word never appears.
- **Overflow:** hold `out_ready` = 0 and send 0x01, 0x02, 0x03.
  - Expect `overflow` = 1 after the 3rd word completes.
  - Popping then yields 0x01 then 0x02; `out_valid` = 0 after that.
  - `clear_ovf` then clears `overflow`.
- **Full plus simultaneous pop:** fill the FIFO, then complete a word 0x77 in the same cycle as a pop.
  - Expect no overflow; occupancy stays at 2.
  - Pop order is 2nd word, then 0x77.
- **Reset mid-operation:** drive `rst` low asynchronously during bit 4 while the FIFO holds one word.
  - Expect all outputs 0 immediately.
  - After release, a fresh 0x5A is received intact with `out_p` = 3'b101.
